toy_cpu: RTL and testbench

- Minimal 8-bit accumulator processor: fetches one-byte opcodes and optional one-byte immediates from an external byte-wide memory bus, executes on an 8-bit accumulator, and writes results to an output port address.
- Top-level teaching/demo block; the memory or stimulus source drives D_IN.
- The six control-FSM states are exported one-hot for debug and LEDs.

---
 rtl/toy_pkg.sv | 32 +++
 rtl/toy_cpu_if.sv | 18 +
 rtl/toy_alu.sv | 28 ++
 rtl/toy_cpu.sv | 107 ++++++++++
 tb/tb_toy_cpu.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/toy_pkg.sv
// ----------------------------------------------------------------------------
// toy_pkg: shared definitions for the toy accumulator CPU.
//   - state_t     : one-hot control FSM encoding (bit i == debug line s<i>)
//   - OP_*        : opcode constants
//   - is_two_byte : true for opcodes that carry an immediate byte
// ----------------------------------------------------------------------------
package toy_pkg;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_FETCH    = 6'b000010,
        S_DECODE   = 6'b000100,
        S_OPERAND  = 6'b001000,
        S_EXECUTE  = 6'b010000,
        S_COMPLETE = 6'b100000
    } state_t;

    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_ADDI = 8'h02;
    localparam logic [7:0] OP_OUT  = 8'h04;
    localparam logic [7:0] OP_ANDI = 8'h08;
    localparam logic [7:0] OP_SUBI = 8'h10;
    localparam logic [7:0] OP_ORI  = 8'h20;

    function automatic logic is_two_byte(input logic [7:0] opcode);
        case (opcode)
            OP_LDI, OP_ADDI, OP_ANDI, OP_SUBI, OP_ORI: is_two_byte = 1'b1;
            default:                                   is_two_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/toy_cpu_if.sv
// ----------------------------------------------------------------------------
// toy_cpu_if: byte-wide memory bus between the CPU and its memory/stimulus.
//   addr   : memory address              (master -> slave)
//   d_out  : write data, mirrors ACC     (master -> slave)
//   mem_en : bus cycle active            (master -> slave)
//   rorw   : 1 = read, 0 = write         (master -> slave)
//   d_in   : read data                   (slave  -> master)
// ----------------------------------------------------------------------------
interface toy_cpu_if;
    logic [7:0] addr;
    logic [7:0] d_out;
    logic [7:0] d_in;
    logic       mem_en;
    logic       rorw;

    modport master (output addr, d_out, mem_en, rorw, input  d_in);
    modport slave  (input  addr, d_out, mem_en, rorw, output d_in);
endinterface

// File: rtl/toy_alu.sv
// ----------------------------------------------------------------------------
// toy_alu: combinational 8-bit ALU for the immediate-operand instructions.
//   op : opcode (IR)   a : accumulator   b : immediate operand
//   y  : new accumulator value; non-ALU opcodes pass a through unchanged.
// ----------------------------------------------------------------------------
module toy_alu
    import toy_pkg::*;
(
    input  logic [7:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    always_comb begin
        // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
        y = a;
        case (op)
            OP_LDI:  y = b;
            OP_ADDI: y = a + b;
            OP_ANDI: y = a & b;
            OP_SUBI: y = a - b;
            OP_ORI:  y = a | b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/toy_cpu.sv
// ----------------------------------------------------------------------------
// toy_cpu: minimal 8-bit accumulator processor.
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high; abandons any instruction in flight
//   bus     : toy_cpu_if master (addr, d_out, mem_en, rorw out; d_in in)
//   s0..s5  : one-hot FSM state for debug/LEDs
// Instruction flow: S1 fetch opcode, S2 decode (PC+1), optional S3 read
// immediate and S4 execute (PC+1, ACC update), S5 complete (OUT write).
// All outputs derive from registers only; d_in feeds registers exclusively.
// ----------------------------------------------------------------------------
module toy_cpu
    import toy_pkg::*;
#(
    parameter logic [7:0] OUT_ADDR = 8'hFF,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    toy_cpu_if.master  bus,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic       s4,
    output logic       s5
);

    state_t     state, state_next;
    logic [7:0] pc, ir, acc, operand;
    logic [7:0] alu_y;
    logic [7:0] addr;
    logic       mem_en, rorw;

    toy_alu u_alu (
        .op (ir),
        .a  (acc),
        .b  (operand),
        .y  (alu_y)
    );

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Datapath registers; each is written only in the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= 8'h00;
            acc     <= 8'h00;
            operand <= 8'h00;
        end else begin
            case (state)
                S_FETCH:   ir      <= bus.d_in;
                S_DECODE:  pc      <= pc + 8'd1;
                S_OPERAND: operand <= bus.d_in;
                S_EXECUTE: begin
                    pc  <= pc + 8'd1;
                    acc <= alu_y;
                end
                default: ;
            endcase
        end
    end

    // Next-state and bus decode
    always_comb begin
        state_next = state;
        addr       = pc;
        mem_en     = 1'b0;
        rorw       = 1'b1;
        case (state)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH: begin
                mem_en     = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE:   state_next = is_two_byte(ir) ? S_OPERAND : S_COMPLETE;
            S_OPERAND: begin
                mem_en     = 1'b1;
                state_next = S_EXECUTE;
            end
            S_EXECUTE:  state_next = S_COMPLETE;
            S_COMPLETE: begin
                if (ir == OP_OUT) begin
                    addr   = OUT_ADDR;
                    mem_en = 1'b1;
                    rorw   = 1'b0;
                end
                state_next = S_FETCH;
            end
            // Unreachable encodings recover through IDLE.
            default:    state_next = S_IDLE;
        endcase
    end

    assign bus.addr   = addr;
    assign bus.mem_en = mem_en;
    assign bus.rorw   = rorw;
    assign bus.d_out  = acc;

    assign {s5, s4, s3, s2, s1, s0} = state;

endmodule

// File: tb/tb_toy_cpu.sv
// ----------------------------------------------------------------------------
// tb_toy_cpu: self-checking bench for toy_cpu. A byte array acts as memory;
// a table of instructions with hand-computed accumulator results is loaded
// as a program and stepped cycle by cycle, followed by hand-written
// sequences for reset, mid-instruction reset and PC wrap-around.
// ----------------------------------------------------------------------------
module tb_toy_cpu;

    localparam logic [7:0] OUT_A = 8'hFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s0, s1, s2, s3, s4, s5;
    logic [5:0] st;
    logic [7:0] mem [256];

    int n_vec = 0;
    int n_bad = 0;
    int onehot_err = 0;
    bit mon_en = 1'b0;

    toy_cpu_if bus ();

    assign bus.d_in = mem[bus.addr];
    assign st = {s5, s4, s3, s2, s1, s0};

    toy_cpu #(.OUT_ADDR(8'hFF), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .s3    (s3),
        .s4    (s4),
        .s5    (s5)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mon_en && $countones(st) != 1) onehot_err++;

    typedef struct {
        string      name;
        logic [7:0] op;
        logic [7:0] imm;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit tb_two(input logic [7:0] op);
        return (op == 8'h01 || op == 8'h02 || op == 8'h08 || op == 8'h10 || op == 8'h20);
    endfunction

    // Starts at the negedge inside S1 of an instruction fetched from fpc and
    // ends at the negedge inside the following S1.
    task automatic run_instr(input string name, input logic [7:0] op,
                             input logic [7:0] exp_acc, input logic [7:0] fpc);
        bit         two = tb_two(op);
        int         n = two ? 5 : 3;
        int         errs = 0;
        logic [5:0] exp_st;
        logic [7:0] ea, np;
        logic       een, erw;
        logic       wr = 1'b0;
        logic [7:0] wa = 8'h00, wd = 8'h00;
        np = fpc + (two ? 8'd2 : 8'd1);
        for (int k = 0; k < n; k++) begin
            if (two) begin
                case (k)
                    0: exp_st = 6'b000010;
                    1: exp_st = 6'b000100;
                    2: exp_st = 6'b001000;
                    3: exp_st = 6'b010000;
                    default: exp_st = 6'b100000;
                endcase
            end else begin
                case (k)
                    0: exp_st = 6'b000010;
                    1: exp_st = 6'b000100;
                    default: exp_st = 6'b100000;
                endcase
            end
            case (exp_st)
                6'b000010: begin ea = fpc;          een = 1'b1; erw = 1'b1; end
                6'b000100: begin ea = fpc;          een = 1'b0; erw = 1'b1; end
                6'b001000: begin ea = fpc + 8'd1;   een = 1'b1; erw = 1'b1; end
                6'b010000: begin ea = fpc + 8'd1;   een = 1'b0; erw = 1'b1; end
                default: begin
                    if (op == 8'h04) begin ea = OUT_A; een = 1'b1; erw = 1'b0; end
                    else             begin ea = np;    een = 1'b0; erw = 1'b1; end
                end
            endcase
            if (st !== exp_st || bus.addr !== ea || bus.mem_en !== een || bus.rorw !== erw)
                errs++;
            if (bus.mem_en === 1'b1 && bus.rorw === 1'b0) begin
                wr = 1'b1;
                wa = bus.addr;
                wd = bus.d_out;
            end
            @(negedge clk);
        end
        check({name, " cycle/bus sequence errors"}, errs, 0);
        check({name, " acc"}, {24'h0, bus.d_out}, {24'h0, exp_acc});
        check({name, " write {en,addr,data}"}, {15'h0, wr, wa, wd},
              (op == 8'h04) ? {15'h0, 1'b1, OUT_A, exp_acc} : 32'h0);
        check({name, " next fetch {s1,addr}"}, {23'h0, s1, bus.addr}, {23'h0, 1'b1, np});
    endtask

    initial begin
        logic [7:0] pc;
        int         errs;

        vecs[0]  = '{"LDI AA",   8'h01, 8'hAA, 8'hAA};
        vecs[1]  = '{"OUT AA",   8'h04, 8'h00, 8'hAA};
        vecs[2]  = '{"LDI FE",   8'h01, 8'hFE, 8'hFE};
        vecs[3]  = '{"ADDI 03",  8'h02, 8'h03, 8'h01};
        vecs[4]  = '{"SUBI FF",  8'h10, 8'hFF, 8'h02};
        vecs[5]  = '{"OUT 02",   8'h04, 8'h00, 8'h02};
        vecs[6]  = '{"ANDI CC",  8'h08, 8'hCC, 8'h00};
        vecs[7]  = '{"LDI 0F",   8'h01, 8'h0F, 8'h0F};
        vecs[8]  = '{"ANDI FE",  8'h08, 8'hFE, 8'h0E};
        vecs[9]  = '{"ORI F0",   8'h20, 8'hF0, 8'hFE};
        vecs[10] = '{"NOP 00",   8'h00, 8'h00, 8'hFE};
        vecs[11] = '{"NOP 37",   8'h37, 8'h00, 8'hFE};
        vecs[12] = '{"NOP FF",   8'hFF, 8'h00, 8'hFE};
        vecs[13] = '{"ADDI 05",  8'h02, 8'h05, 8'h03};
        vecs[14] = '{"NOP 40",   8'h40, 8'h00, 8'h03};
        vecs[15] = '{"OUT 03",   8'h04, 8'h00, 8'h03};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        pc = 8'h00;
        for (int i = 0; i < 16; i++) begin
            mem[pc] = vecs[i].op;
            pc++;
            if (tb_two(vecs[i].op)) begin
                mem[pc] = vecs[i].imm;
                pc++;
            end
        end

        // Reset: one edge with reset high, then S0 for one cycle, then fetch.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset state", {26'h0, st}, 32'h01);
        check("reset bus {addr,en,rw}", {22'h0, bus.addr, bus.mem_en, bus.rorw}, {22'h0, 8'h00, 1'b0, 1'b1});
        check("reset acc", {24'h0, bus.d_out}, 32'h0);
        @(negedge clk);
        check("first fetch {st,addr,en,rw}", {16'h0, st, bus.addr, bus.mem_en, bus.rorw},
              {16'h0, 6'b000010, 8'h00, 1'b1, 1'b1});

        // Table-driven program run.
        pc = 8'h00;
        for (int i = 0; i < 16; i++) begin
            run_instr(vecs[i].name, vecs[i].op, vecs[i].exp_acc, pc);
            pc = pc + (tb_two(vecs[i].op) ? 8'd2 : 8'd1);
        end

        // Reset during S3 of LDI 55: instruction abandoned, no load.
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h01;
        mem[1] = 8'h55;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset with acc nonzero: acc", {24'h0, bus.d_out}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("LDI 55 reached S3", {26'h0, st}, 32'h08);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mem[0] = 8'h00;
        @(negedge clk);
        check("abort -> S0", {26'h0, st}, 32'h01);
        check("abort pc/acc {addr,acc}", {16'h0, bus.addr, bus.d_out}, {16'h0, 8'h00, 8'h00});
        @(negedge clk);
        run_instr("NOP after abort", 8'h00, 8'h00, 8'h00);

        // PC wrap: NOPs through 0xFE quietly, then the NOP at 0xFF wraps to 0x00.
        errs = 0;
        pc = 8'h01;
        for (int i = 0; i < 254; i++) begin
            if (st !== 6'b000010 || bus.addr !== pc) errs++;
            repeat (3) @(negedge clk);
            pc++;
        end
        check("NOP run fetch address errors", errs, 0);
        run_instr("NOP at FF wraps", 8'h00, 8'h00, 8'hFF);

        check("one-hot violations", onehot_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
